// File: rtl/sram_cfg_pkg.sv
// SRAM width configuration shared by the write lane mask and the
// read alignment path: encodings, widths and read side-info.
package sram_cfg_pkg;

   localparam logic [1:0] CONF_32  = 2'b00;
   localparam logic [1:0] CONF_16  = 2'b01;
   localparam logic [1:0] CONF_8   = 2'b10;
   localparam logic [1:0] CONF_ILL = 2'b11;

   localparam int LANE_W = 8;
   localparam int ROW_W  = 32;

   typedef struct packed {
      logic       v;
      logic [1:0] addr;
      logic [1:0] conf;
      logic       sext;
   } side_t;

   typedef struct packed {
      logic [ROW_W-1:0] data;
      logic             err;
   } rsp_t;

endpackage

// File: rtl/rd_lane_extract.sv
// Combinational lane extraction: selects a half or byte from a raw
// row, right-aligns it and zero- or sign-extends it.
module rd_lane_extract
   import sram_cfg_pkg::*;
(
   input  logic [ROW_W-1:0] rdata,
   input  logic [1:0]       addr,
   input  logic [1:0]       conf,
   input  logic             sext,
   output logic [ROW_W-1:0] data,
   output logic             err
);

   logic [2*LANE_W-1:0] half;
   logic [LANE_W-1:0]   lane;

   // select the addressed lane, then extend it to the row width
   always_comb begin
      half = addr[0] ? rdata[31:16] : rdata[15:0];
      lane = rdata[{addr, 3'b000} +: LANE_W];
      data = '0;
      err  = 1'b0;
      unique case (conf)
         CONF_32: data = rdata;
         CONF_16: data = {{16{sext & half[15]}}, half};
         CONF_8:  data = {{24{sext & lane[7]}}, lane};
         default: err  = 1'b1;
      endcase
   end

endmodule

// File: rtl/rd_align_8_32_3.sv
// SRAM read-return path: tracks side-info through the macro latency,
// aligns the returned lane and buffers results in a credit FIFO.
module rd_align_8_32_3
   import sram_cfg_pkg::*;
#(
   parameter int SRAM_LAT = 1,
   parameter int DEPTH    = SRAM_LAT + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_addr,
   input  logic [1:0]       req_conf,
   input  logic             req_sext,
   input  logic [ROW_W-1:0] sram_rdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [ROW_W-1:0] rsp_data,
   output logic             rsp_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + SRAM_LAT + 1);

   side_t            pipe [SRAM_LAT];
   rsp_t             mem  [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [CW-1:0]    occ;
   logic [CW-1:0]    inflight;
   logic             accept;
   logic             push;
   logic             pop;
   logic [ROW_W-1:0] ext_data;
   logic             ext_err;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // count outstanding reads that still hold a FIFO credit
   always_comb begin
      inflight = '0;
      for (int i = 0; i < SRAM_LAT; i++) begin
         inflight = inflight + CW'(pipe[i].v);
      end
   end

   assign req_ready = !rst && ((inflight + occ) < CW'(DEPTH));
   assign accept    = req_valid && req_ready;
   assign push      = pipe[SRAM_LAT-1].v;
   assign rsp_valid = (occ != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_data  = mem[rptr].data;
   assign rsp_err   = mem[rptr].err;

   rd_lane_extract u_extract (
      .rdata (sram_rdata),
      .addr  (pipe[SRAM_LAT-1].addr),
      .conf  (pipe[SRAM_LAT-1].conf),
      .sext  (pipe[SRAM_LAT-1].sext),
      .data  (ext_data),
      .err   (ext_err)
   );

   // side-info pipeline aligned with the macro read latency
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SRAM_LAT; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= '{v: accept, addr: req_addr,
                      conf: req_conf, sext: req_sext};
         for (int i = 1; i < SRAM_LAT; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   // response FIFO; credits guarantee a push never meets a full FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wptr] <= '{data: ext_data, err: ext_err};
            wptr      <= nxt(wptr);
         end
         if (pop) begin
            rptr <= nxt(rptr);
         end
         occ <= occ + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_rd_align_8_32_3.sv
// Directed bench for rd_align_8_32_3: instance A (LAT 1, DEPTH 3)
// and instance B (LAT 2, DEPTH 3), each fed by a small SRAM model.
module tb_rd_align_8_32_3;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   logic        a_req_valid, a_req_ready, a_req_sext;
   logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [1:0]  a_req_addr, a_req_conf;
   logic [31:0] a_row, a_rdata, a_rsp_data;

   logic        b_req_valid, b_req_ready, b_req_sext;
   logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [1:0]  b_req_addr, b_req_conf;
   logic [31:0] b_row, b_rdata, b_rsp_data, b_r1;

   rd_align_8_32_3 #(.SRAM_LAT(1), .DEPTH(3)) u_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_addr(a_req_addr), .req_conf(a_req_conf),
      .req_sext(a_req_sext), .sram_rdata(a_rdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_data(a_rsp_data), .rsp_err(a_rsp_err)
   );

   rd_align_8_32_3 #(.SRAM_LAT(2), .DEPTH(3)) u_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_addr(b_req_addr), .req_conf(b_req_conf),
      .req_sext(b_req_sext), .sram_rdata(b_rdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
   );

   // SRAM macro models: row valid SRAM_LAT cycles after acceptance
   always @(posedge clk) begin
      a_rdata <= (a_req_valid && a_req_ready) ? a_row : 32'hDEAD_BEEF;
      b_r1    <= (b_req_valid && b_req_ready) ? b_row : 32'hDEAD_BEEF;
      b_rdata <= b_r1;
   end

   function automatic logic [32:0] ref_rsp(input logic [31:0] row,
                                           input logic [1:0] addr,
                                           input logic [1:0] conf,
                                           input logic sext);
      logic [31:0] sh;
      if (conf == 2'b11) return {1'b1, 32'h0};
      if (conf == 2'b00) return {1'b0, row};
      if (conf == 2'b01) begin
         sh = row >> (addr[0] ? 16 : 0);
         if (sext && sh[15]) return {1'b0, 16'hFFFF, sh[15:0]};
         return {1'b0, 16'h0, sh[15:0]};
      end
      sh = row >> (8 * addr);
      if (sext && sh[7]) return {1'b0, 24'hFFFFFF, sh[7:0]};
      return {1'b0, 24'h0, sh[7:0]};
   endfunction

   task automatic test_reset();
      logic seen;
      rst = 1'b1;
      a_req_valid = 1'b1;
      b_req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (a_rsp_valid !== 1'b0 || a_rsp_data !== 32'h0 ||
             a_req_ready !== 1'b0 || a_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: valid=%b data=%h ready=%b want 0/0/0",
                     a_rsp_valid, a_rsp_data, a_req_ready);
         end
         checks++;
         if (b_rsp_valid !== 1'b0 || b_rsp_data !== 32'h0 ||
             b_req_ready !== 1'b0 || b_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: valid=%b data=%h ready=%b want 0/0/0",
                     b_rsp_valid, b_rsp_data, b_req_ready);
         end
      end
      rst = 1'b0;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      #1;
      checks++;
      if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset: a=%b b=%b want 1",
                  a_req_ready, b_req_ready);
      end
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: response seen=%b want 0", seen);
      end
   endtask

   task automatic test_widths();
      logic [1:0]  cf [10] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1,
                               2'd2, 2'd0, 2'd1, 2'd2, 2'd1};
      logic [1:0]  ad [10] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd0,
                               2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
      logic        sx [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] ex [10] = '{32'h8F7EA1B2, 32'hFFFF8F7E, 32'h000000B2,
                               32'hFFFFFF8F, 32'h0000A1B2, 32'hFFFFFFA1,
                               32'h8F7EA1B2, 32'h00008F7E, 32'h0000007E,
                               32'hFFFFA1B2};
      a_rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a_req_valid = 1'b1;
         a_row       = 32'h8F7EA1B2;
         a_req_conf  = cf[i];
         a_req_addr  = ad[i];
         a_req_sext  = sx[i];
         #1;
         checks++;
         if (a_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL width_ready[%0d]: got %b want 1", i, a_req_ready);
         end
         @(negedge clk);
         a_req_valid = 1'b0;
         checks++;
         if (a_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL width_early[%0d]: valid=%b want 0", i, a_rsp_valid);
         end
         @(negedge clk);
         checks++;
         if (a_rsp_valid !== 1'b1 || a_rsp_data !== ex[i] ||
             a_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL width[%0d]: v=%b d=%h e=%b want 1 %h 0",
                     i, a_rsp_valid, a_rsp_data, a_rsp_err, ex[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] rw [4] = '{32'h8F7EA1B2, 32'h8F7EA1B2,
                              32'hFFFFFFFF, 32'h12345680};
      logic [1:0]  cf [4] = '{2'd3, 2'd2, 2'd3, 2'd2};
      logic [1:0]  ad [4] = '{2'd2, 2'd2, 2'd0, 2'd0};
      logic        sx [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] ex [4] = '{32'h0, 32'h0000007E, 32'h0, 32'hFFFFFF80};
      logic        er [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      a_rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a_req_valid = 1'b1;
         a_row       = rw[i];
         a_req_conf  = cf[i];
         a_req_addr  = ad[i];
         a_req_sext  = sx[i];
         @(negedge clk);
         a_req_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (a_rsp_valid !== 1'b1 || a_rsp_data !== ex[i] ||
             a_rsp_err !== er[i]) begin
            failures++;
            $display("FAIL illegal[%0d]: v=%b d=%h e=%b want 1 %h %b",
                     i, a_rsp_valid, a_rsp_data, a_rsp_err, ex[i], er[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic exp_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      int   acc = 0;
      b_rsp_ready = 1'b0;
      b_req_conf  = 2'd0;
      b_req_addr  = 2'd0;
      b_req_sext  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         b_req_valid = 1'b1;
         b_row       = 32'hC0DE0000 | i;
         #1;
         checks++;
         if (b_req_ready !== exp_rdy[i]) begin
            failures++;
            $display("FAIL bp_ready[%0d]: got %b want %b",
                     i, b_req_ready, exp_rdy[i]);
         end
         if (b_req_ready === 1'b1) acc++;
      end
      @(negedge clk);
      b_req_valid = 1'b0;
      checks++;
      if (acc != 3) begin
         failures++;
         $display("FAIL bp_accepted: got %0d want 3", acc);
      end
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'hC0DE0000 ||
          b_req_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_full: v=%b d=%h rdy=%b want 1 c0de0000 0",
                  b_rsp_valid, b_rsp_data, b_req_ready);
      end
      @(negedge clk);
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'hC0DE0000) begin
         failures++;
         $display("FAIL bp_hold: v=%b d=%h want 1 c0de0000",
                  b_rsp_valid, b_rsp_data);
      end
      b_rsp_ready = 1'b1;
      #1;
      checks++;
      if (b_req_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_ready_pre_pop: got %b want 0", b_req_ready);
      end
      @(negedge clk);
      checks++;
      if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b1 ||
          b_rsp_data !== 32'hC0DE0001) begin
         failures++;
         $display("FAIL bp_pop1: rdy=%b v=%b d=%h want 1 1 c0de0001",
                  b_req_ready, b_rsp_valid, b_rsp_data);
      end
      @(negedge clk);
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'hC0DE0002) begin
         failures++;
         $display("FAIL bp_pop2: v=%b d=%h want 1 c0de0002",
                  b_rsp_valid, b_rsp_data);
      end
      @(negedge clk);
      checks++;
      if (b_rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_drained: v=%b want 0", b_rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [32:0] q [$];
      logic [32:0] exp;
      int sent = 0;
      int got  = 0;
      int gaps = 0;
      a_rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 120 && got < 64; cyc++) begin
         @(negedge clk);
         if (a_rsp_valid === 1'b1) begin
            got++;
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra: d=%h with no request", a_rsp_data);
            end else begin
               exp = q.pop_front();
               if ({a_rsp_err, a_rsp_data} !== exp) begin
                  failures++;
                  $display("FAIL b2b[%0d]: got %b/%h want %b/%h", got,
                           a_rsp_err, a_rsp_data, exp[32], exp[31:0]);
               end
            end
         end else if (got > 0) begin
            gaps++;
         end
         if (sent < 64) begin
            checks++;
            if (a_req_ready !== 1'b1) begin
               failures++;
               $display("FAIL b2b_ready[%0d]: got %b want 1",
                        sent, a_req_ready);
            end
            a_req_valid = 1'b1;
            a_row       = $urandom;
            a_req_conf  = 2'($urandom_range(0, 3));
            a_req_addr  = 2'($urandom_range(0, 3));
            a_req_sext  = 1'($urandom_range(0, 1));
            if (a_req_ready === 1'b1) begin
               q.push_back(ref_rsp(a_row, a_req_addr,
                                   a_req_conf, a_req_sext));
               sent++;
            end
         end else begin
            a_req_valid = 1'b0;
         end
      end
      a_req_valid = 1'b0;
      checks++;
      if (got != 64) begin
         failures++;
         $display("FAIL b2b_count: got %0d want 64 (cycle bound)", got);
      end
      checks++;
      if (gaps != 0) begin
         failures++;
         $display("FAIL b2b_gaps: got %0d idle cycles want 0", gaps);
      end
   endtask

   task automatic test_reset_midstream();
      logic stale;
      b_rsp_ready = 1'b0;
      b_req_conf  = 2'd0;
      b_req_addr  = 2'd0;
      b_req_sext  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         b_req_valid = 1'b1;
         b_row       = 32'h5A5A0000 | i;
      end
      @(negedge clk);
      b_req_valid = 1'b0;
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'h5A5A0000) begin
         failures++;
         $display("FAIL mid_pre: v=%b d=%h want 1 5a5a0000",
                  b_rsp_valid, b_rsp_data);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (b_req_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst_ready: got %b want 0", b_req_ready);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (b_rsp_valid !== 1'b0 || b_rsp_data !== 32'h0 ||
             b_rsp_err !== 1'b0 || b_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst: v=%b d=%h e=%b rdy=%b want 0",
                     b_rsp_valid, b_rsp_data, b_rsp_err, b_req_ready);
         end
      end
      rst = 1'b0;
      b_rsp_ready = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (b_rsp_valid !== 1'b0) stale = 1'b1;
      end
      checks++;
      if (stale !== 1'b0) begin
         failures++;
         $display("FAIL mid_stale: response seen=%b want 0", stale);
      end
      b_req_valid = 1'b1;
      b_row       = 32'h80001234;
      b_req_conf  = 2'd1;
      b_req_addr  = 2'd1;
      b_req_sext  = 1'b0;
      #1;
      checks++;
      if (b_req_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_ready: got %b want 1", b_req_ready);
      end
      @(negedge clk);
      b_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (b_rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_early: v=%b want 0", b_rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'h00008000 ||
          b_rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL mid_first: v=%b d=%h e=%b want 1 00008000 0",
                  b_rsp_valid, b_rsp_data, b_rsp_err);
      end
   endtask

   initial begin
      rst         = 1'b1;
      a_req_valid = 1'b0;
      a_req_addr  = 2'd0;
      a_req_conf  = 2'd0;
      a_req_sext  = 1'b0;
      a_row       = 32'h0;
      a_rsp_ready = 1'b0;
      b_req_valid = 1'b0;
      b_req_addr  = 2'd0;
      b_req_conf  = 2'd0;
      b_req_sext  = 1'b0;
      b_row       = 32'h0;
      b_rsp_ready = 1'b0;
      test_reset();
      test_widths();
      test_illegal();
      test_backpressure();
      test_back_to_back();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
